period_meter: RTL
=================

# period_meter

Measures the period and high time of a slow, asynchronous square-wave input in `clk` cycles. It is the receiving counterpart of the clock divider: the divider turns a fast count into a slow clock, and this block turns a slow clock back into a count. It sits beside the divider to self-check divided clocks and to measure external slow signals such as buttons or sensors. Results go to the display and debug logic as a registered value with a one-cycle valid strobe.

## Interface
- `WIDTH`, default 26: width of the counter and result. 26 covers one full period of the 25-bit divider output (2^25 cycles).
- `SYNC_STAGES`, default 2: number of synchronizer flops on `sig_in`. Must be at least 2.
- `clk`  input  1: system clock. All logic is on its rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `sig_in`  input  1: signal under measurement. Asynchronous to `clk`.
- `period`  output  WIDTH: `clk` cycles between the last two detected rising edges.
- `high_time`  output  WIDTH: `clk` cycles from the rising edge to the falling edge within that same period.
- `period_valid`  output  1: one-cycle strobe. Asserted when `period` and `high_time` update.
- `no_signal`  output  1: high while no rising edge has been seen for 2^WIDTH−1 cycles.

## Operation
- **Input conditioning:** `sig_in` passes through `SYNC_STAGES` flops, then a delay flop.
  - `rise` = sync & ~delay.
  - `fall` = ~sync & delay.
  - `rise` and `fall` are never both asserted in the same cycle.
- **Counter `cnt` (WIDTH bits):**
  - Set to 1 on `rise`.
  - Otherwise increments by 1 per cycle, saturating at MAX = 2^WIDTH−1.
  - Never wraps.
- **State machine:** states IDLE, MEASURE, TIMEOUT.
  - IDLE: waits for the first `rise`. On `rise`, load `cnt`=1 and go to MEASURE. No strobe.
  - MEASURE, on `fall`: latch `hi_lat` ← `cnt`.
  - MEASURE, on `rise`:
    - `period` ← `cnt`.
    - `high_time` ← `hi_lat`.
    - `period_valid` ← 1.
    - `cnt` ← 1.
    - Stay in MEASURE.
  - MEASURE, when `cnt`==MAX with no `rise` that cycle: go to TIMEOUT and set `no_signal` ← 1. `period` and `high_time` hold.
  - MEASURE, when `rise` arrives in the same cycle as `cnt`==MAX: the rise wins. Report `period`=MAX and stay in MEASURE.
  - TIMEOUT: `cnt` holds at MAX.
  - TIMEOUT, on `rise`: go to MEASURE, load `cnt`=1, clear `no_signal`. No strobe, because this rise is treated as the first edge.
- **Result meaning:**
  - A rising edge every N cycles reports `period`=N.
  - Low time is `period`−`high_time` and is not output.
  - `high_time` < `period` always holds for any measured period.
- **Pulse width:** `sig_in` pulses shorter than one `clk` period may be missed. This is acceptable and is not flagged.

## Timing
- **Reset values:**
  - Outputs: `period`=0, `high_time`=0, `period_valid`=0, `no_signal`=0.
  - Internals: state IDLE, `cnt`=0, `hi_lat`=0, synchronizer and delay flops 0.
- **Reset asserted mid-measurement:**
  - Everything clears immediately, without waiting for a clock.
  - The first `rise` after release only re-arms the block. No strobe is produced for it.
- **`sig_in` high at reset release:** this produces a `rise`, which counts as the first (arming) edge.
- **Latency:**
  - Take the first `clk` edge that samples `sig_in` high as edge 1.
  - `rise` is asserted in the cycle after edge `SYNC_STAGES`+1.
  - `period_valid` and the new `period` appear after edge `SYNC_STAGES`+2.
  - `fall` to `hi_lat` update has the same latency.
- **Strobe:** `period_valid` is exactly one cycle wide. It is never asserted on two consecutive cycles, because that would need `period`=1, which a synchronized signal cannot produce.
- **Output stability:** all outputs are registered and hold their values between strobes.

## Structure
- **Shared package `meas_pkg`:**
  - State encoding localparams: ST_IDLE=2'd0, ST_MEASURE=2'd1, ST_TIMEOUT=2'd2.
  - Default `WIDTH` constant, shared with the divider's counter width.
- **Sub-module `sync_edge_det`:**
  - Parameterized by `SYNC_STAGES`.
  - Contains the synchronizer chain and delay flop.
  - Outputs `level`, `rise`, `fall`.
  - Async reset to 0.
  - Reusable for button inputs elsewhere.
- **Top level:** `cnt`, `hi_lat`, the FSM and the output registers.

## Test plan
- **Regular signal:** `sig_in` period 10 cycles, high for 3 (WIDTH=26). The first strobe follows the second rise and reports `period`=10, `high_time`=3. Every later rise strobes with the same values.
- **Divider-driven:** drive `sig_in` from bit 3 of a free-running counter on `clk`. Reports `period`=16, `high_time`=8. `no_signal` stays 0.
- **Timeout:** WIDTH=6, so MAX=63. Toggle `sig_in` with period 8 to get one valid strobe, then hold low for 70 cycles.
  - `no_signal`=1 after `cnt` reaches 63, with no strobe.
  - `period` holds at 8.
  - The next rise clears `no_signal` without a strobe.
  - The following rise, 8 cycles later, strobes with `period`=8.
- **Saturation tie:** WIDTH=6. Arrange `rise` exactly in the cycle where `cnt`=63. Strobe with `period`=63 and `no_signal` stays 0.
- **Mid-measurement reset:** assert `reset` between clock edges while in MEASURE.
  - All outputs read 0 before the next `clk` edge.
  - After release, the first rise gives no strobe.
  - The second rise strobes with the correct period.
- **Latency:** with `SYNC_STAGES`=3, measure from the sampling edge to `period_valid`. It must be exactly 5 edges.

Source files
------------

// File: rtl/meas_pkg.sv
// Shared definitions for the slow-signal measurement blocks (period meter, divider checks).
package meas_pkg;

    localparam int DEFAULT_WIDTH = 26;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_MEASURE = ST_MEASURE,
        S_TIMEOUT = ST_TIMEOUT
    } meas_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level and produces registered one-cycle rise/fall pulses.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_delay;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_delay <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_delay <= w_sync;
            // Edge pulses are registered so downstream logic sees clean single-cycle strobes.
            r_rise  <= w_sync & ~r_delay;
            r_fall  <= ~w_sync & r_delay;
        end
    end

    assign level = w_sync;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// with a saturating counter and a timeout flag when edges stop arriving.
module period_meter
    import meas_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             period_valid,
    output logic             no_signal
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             w_level_unused;
    logic             w_rise;
    logic             w_fall;

    meas_state_t      r_state;
    meas_state_t      w_state_next;
    logic             w_strobe;
    logic             w_latch_hi;
    logic             w_set_nosig;
    logic             w_clr_nosig;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi_lat;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high_time;
    logic             r_period_valid;
    logic             r_no_signal;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .clk   (clk),
        .reset (reset),
        .sig_in(sig_in),
        .level (w_level_unused),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_strobe     = 1'b0;
        w_latch_hi   = 1'b0;
        w_set_nosig  = 1'b0;
        w_clr_nosig  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                w_latch_hi = w_fall;
                // A rise coinciding with saturation still reports, so the tie favours the edge.
                if (w_rise) begin
                    w_strobe = 1'b1;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next = S_TIMEOUT;
                    w_set_nosig  = 1'b1;
                end
            end
            S_TIMEOUT: begin
                if (w_rise) begin
                    w_state_next = S_MEASURE;
                    w_clr_nosig  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt          <= '0;
            r_hi_lat       <= '0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_no_signal    <= 1'b0;
        end else begin
            if (w_rise) begin
                r_cnt <= WIDTH'(1);
            end else if ((r_state != S_IDLE) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end

            if (w_latch_hi) begin
                r_hi_lat <= r_cnt;
            end

            r_period_valid <= w_strobe;
            if (w_strobe) begin
                r_period    <= r_cnt;
                r_high_time <= r_hi_lat;
            end

            if (w_set_nosig) begin
                r_no_signal <= 1'b1;
            end else if (w_clr_nosig) begin
                r_no_signal <= 1'b0;
            end
        end
    end

    assign period       = r_period;
    assign high_time    = r_high_time;
    assign period_valid = r_period_valid;
    assign no_signal    = r_no_signal;

endmodule
